// File: rtl/load_store_unit.sv
// Load/store unit between the core data port and a word-addressed data memory.
// Latency: at least 2 cycles per access (the first cycle always stalls), then it follows mem_ready_i.
// Backpressure: core_stall_o holds the core until the memory signals ready; dropping core_req_i aborts.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   core_req_i/we/size/addr/wd   core request (funct3 size encoding), held while stalled
//   core_rd_o, core_stall_o      extended load data, stall back to the core
//   mem_req/we/be/addr/wd_o      memory request with byte enables and lane-replicated write data
//   mem_rd_i, mem_ready_i        memory read word and completion strobe
module load_store_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_done;
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic [31:0] w_rd;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // mem_ready_i only counts once the request has been registered in WAIT,
    // which forces every access to spend its first cycle stalled.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (core_req_i) w_state_nxt = WAIT;
            WAIT: if (!core_req_i || mem_ready_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_done = (r_state == WAIT) && mem_ready_i;

    // Byte enables; unsupported sizes get no lanes but still handshake.
    always_comb begin
        w_be = 4'b0000;
        case (core_size_i)
            3'd0, 3'd4: w_be = 4'b0001 << core_addr_i[1:0];
            3'd1, 3'd5: w_be = 4'b0011 << {core_addr_i[1], 1'b0};
            3'd2:       w_be = 4'b1111;
            default:    w_be = 4'b0000;
        endcase
    end

    // Store data is replicated across all lanes so the byte enables alone pick the target.
    always_comb begin
        w_wd = core_wd_i;
        case (core_size_i[1:0])
            2'd0:    w_wd = {4{core_wd_i[7:0]}};
            2'd1:    w_wd = {2{core_wd_i[15:0]}};
            default: w_wd = core_wd_i;
        endcase
    end

    // Load lane extraction; word loads ignore addr[1:0], halfword loads ignore addr[0].
    always_comb begin
        w_byte = mem_rd_i[7:0];
        case (core_addr_i[1:0])
            2'd0: w_byte = mem_rd_i[7:0];
            2'd1: w_byte = mem_rd_i[15:8];
            2'd2: w_byte = mem_rd_i[23:16];
            2'd3: w_byte = mem_rd_i[31:24];
            default: w_byte = mem_rd_i[7:0];
        endcase
    end

    assign w_half = core_addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

    always_comb begin
        w_rd = 32'h0;
        case (core_size_i)
            3'd0:    w_rd = {{24{w_byte[7]}}, w_byte};
            3'd4:    w_rd = {24'h0, w_byte};
            3'd1:    w_rd = {{16{w_half[15]}}, w_half};
            3'd5:    w_rd = {16'h0, w_half};
            3'd2:    w_rd = mem_rd_i;
            default: w_rd = 32'h0;
        endcase
    end

    // Memory-side outputs are gated by core_req_i so an idle or aborted port shows all zeros.
    assign core_stall_o = core_req_i && !w_done;
    assign core_rd_o    = w_rd;
    assign mem_req_o    = core_req_i;
    assign mem_we_o     = core_req_i && core_we_i;
    assign mem_be_o     = core_req_i ? w_be : 4'b0000;
    assign mem_addr_o   = core_req_i ? core_addr_i : 32'h0;
    assign mem_wd_o     = core_req_i ? w_wd : 32'h0;

endmodule
